// File: rtl/ps2_scancode_buffer_pkg.sv
// Shared PS/2 receiver types, protocol byte constants and parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] PS2_BREAK        = 8'hF0;
  localparam logic [7:0] PS2_EXT          = 8'hE0;
  localparam logic [7:0] PS2_BKSP_DEFAULT = 8'h66;

  // PS/2 uses odd parity across the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser, ps2_clk glitch filter and 11-bit frame receiver with timeout.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined; otherwise it is sampled and ignored.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_filt;
  logic [FW-1:0] r_filt_cnt;
  logic          r_fall;

  rx_state_t     r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [TW-1:0] r_to_cnt;
  logic          r_byte_vld;
  logic [7:0]    r_byte;
  logic          r_err;
  logic          w_par_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic r_par;
  assign w_par_ok = odd_parity_ok(r_shift, r_par);
`else
  assign w_par_ok = 1'b1;
`endif

  // A level change on ps2_clk is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_fall   <= 1'b0;
      if (r_clk_s2 != r_clk_filt) begin
        if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
          r_clk_filt <= r_clk_s2;
          r_filt_cnt <= '0;
          r_fall     <= ~r_clk_s2;
        end else begin
          r_filt_cnt <= r_filt_cnt + FW'(1);
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_to_cnt   <= '0;
      r_byte_vld <= 1'b0;
      r_byte     <= '0;
      r_err      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_byte_vld <= 1'b0;
      r_err      <= 1'b0;
      if (r_fall) begin
        r_to_cnt <= '0;
      end else if (r_state != IDLE) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end

      if (r_state != IDLE && !r_fall && r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
        r_err    <= 1'b1;
        r_state  <= IDLE;
        r_to_cnt <= '0;
      end else if (r_fall) begin
        unique case (r_state)
          IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end
          end
          DATA: begin
            r_shift <= {r_dat_s2, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            r_par <= r_dat_s2;
`endif
            r_state <= STOP;
          end
          STOP: begin
            if (r_dat_s2 && w_par_ok) begin
              r_byte_vld <= 1'b1;
              r_byte     <= r_shift;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign byte_valid = r_byte_vld;
  assign rx_byte    = r_byte;
  assign frame_err  = r_err;

endmodule

// File: rtl/ps2_scancode_buffer.sv
// PS/2 keyboard receiver with break/extended stripping and a DIGITS-deep make-code history.
// PS2_PARITY_CHECK_EN (optional define) enables odd-parity enforcement in the frame receiver.
module ps2_scancode_buffer
  import ps2_pkg::*;
#(
  parameter int         DIGITS      = 8,
  parameter int         FILTER_LEN  = 4,
  parameter int         TIMEOUT_CYC = 5000,
  parameter logic [7:0] BKSP_CODE   = PS2_BKSP_DEFAULT,
  localparam int        CW          = $clog2(DIGITS + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [DIGITS*8-1:0] key_buf,
  output logic [CW-1:0]       key_count,
  output logic                key_valid,
  output logic [7:0]          key_code,
  output logic                frame_err
);

  logic                w_byte_vld;
  logic [7:0]          w_byte;
  logic                w_frame_err;

  logic [DIGITS*8-1:0] r_buf;
  logic [CW-1:0]       r_count;
  logic                r_valid;
  logic [7:0]          r_code;
  logic                r_brk;
  logic                r_ext;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk        (CLK),
    .rst        (RST),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (w_byte_vld),
    .rx_byte    (w_byte),
    .frame_err  (w_frame_err)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_buf   <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_code  <= '0;
      r_brk   <= 1'b0;
      r_ext   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_byte_vld) begin
        if (w_byte == PS2_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte == PS2_BREAK) begin
          r_brk <= 1'b1;
        end else if (r_brk) begin
          r_brk <= 1'b0;
          r_ext <= 1'b0;
        end else begin
          // The E0 prefix only qualifies the code; the stored value is the bare make code.
          if (r_ext) r_ext <= 1'b0;
          r_code  <= w_byte;
          r_valid <= 1'b1;
          if (w_byte != BKSP_CODE) begin
            r_buf <= {r_buf[DIGITS*8-9:0], w_byte};
            if (r_count != CW'(DIGITS)) r_count <= r_count + CW'(1);
          end else if (r_count != '0) begin
            r_buf   <= {8'h00, r_buf[DIGITS*8-1:8]};
            r_count <= r_count - CW'(1);
          end
        end
      end
    end
  end

  assign key_buf   = r_buf;
  assign key_count = r_count;
  assign key_valid = r_valid;
  assign key_code  = r_code;
  assign frame_err = w_frame_err;

endmodule
